// File: rtl/sdp_ram_burst_reader_if.sv
// Bus bundle for sdp_ram_burst_reader.
// Carries the three channels that surround the reader:
//   cmd_*              burst command (valid/ready), start address and word count
//   address_b, rden_b  RAM port-B read request; q_b read data one cycle later
//   out_*              word stream (valid/ready) with end-of-burst marker
//   busy               a burst is in progress
// Modport master is the reader side; modport slave is the surrounding system
// (command source, RAM and downstream consumer).
interface sdp_ram_burst_reader_if #(
    parameter int unsigned width_b   = 8,
    parameter int unsigned widthad_b = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [widthad_b-1:0] cmd_addr;
    logic [widthad_b:0]   cmd_len;
    logic [widthad_b-1:0] address_b;
    logic                 rden_b;
    logic [width_b-1:0]   q_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [width_b-1:0]   out_data;
    logic                 out_last;
    logic                 busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, q_b, out_ready,
        output cmd_ready, address_b, rden_b, out_valid, out_data, out_last, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, q_b, out_ready,
        input  cmd_ready, address_b, rden_b, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/sdp_ram_burst_reader.sv
// Burst read master for a simple dual-port RAM (port B side).
// Accepts {cmd_addr, cmd_len}, issues cmd_len reads with address wrap at
// numwords_b, and streams the returned words on a valid/ready interface with
// out_last on the final word. The RAM's 1-cycle read latency is absorbed by a
// 4-slot skid buffer (output register + 3-entry FIFO); a read is only issued
// when every outstanding word is guaranteed a slot.
// Ports:
//   clock0   rising-edge clock
//   aclr0_n  asynchronous active-low reset
//   bus      sdp_ram_burst_reader_if.master (command, RAM port B, stream, busy)
module sdp_ram_burst_reader #(
    parameter int unsigned width_b    = 8,
    parameter int unsigned widthad_b  = 8,
    parameter int unsigned numwords_b = 256
) (
    input logic                     clock0,
    input logic                     aclr0_n,
    sdp_ram_burst_reader_if.master  bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [widthad_b-1:0] LastAddr = widthad_b'(numwords_b - 1);
    localparam logic [widthad_b:0]   LenOne   = (widthad_b + 1)'(1);

    function automatic logic [widthad_b-1:0] addr_inc(input logic [widthad_b-1:0] a);
        return (a == LastAddr) ? '0 : a + widthad_b'(1);
    endfunction

    // FIFO pointers run modulo 3.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [widthad_b-1:0] next_addr_q, next_addr_d;
    logic [widthad_b:0]   rem_q, rem_d;        // reads still to be issued
    logic                 rden_q, rden_d;
    logic [widthad_b-1:0] addr_q, addr_d;
    logic                 rd_last_q, rd_last_d;     // the read on the bus is the burst's last
    logic                 pend_q, pend_d;           // q_b carries a requested word this cycle
    logic                 pend_last_q, pend_last_d;

    logic [width_b-1:0]   fifo_data_q [3];
    logic [width_b-1:0]   fifo_data_d [3];
    logic [2:0]           fifo_last_q, fifo_last_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [2:0]           fcnt_q, fcnt_d;

    logic                 out_valid_q, out_valid_d;
    logic [width_b-1:0]   out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 cmd_ready_q, cmd_ready_d;

    logic                 pop, slot_free, fifo_push, fifo_pop, credit;
    logic [2:0]           occ_d;

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fcnt_d      = fcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        pop       = out_valid_q & bus.out_ready;
        slot_free = ~out_valid_q | pop;
        fifo_pop  = slot_free & (fcnt_q != 3'd0);
        // Returning data bypasses the FIFO only when it is empty and the output slot frees.
        fifo_push = pend_q & ~(slot_free & (fcnt_q == 3'd0));

        if (slot_free) begin
            if (fcnt_q != 3'd0) begin
                out_valid_d = 1'b1;
                out_data_d  = fifo_data_q[rd_ptr_q];
                out_last_d  = fifo_last_q[rd_ptr_q];
            end else if (pend_q) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.q_b;
                out_last_d  = pend_last_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (fifo_push) begin
            fifo_data_d[wr_ptr_q] = bus.q_b;
            fifo_last_d[wr_ptr_q] = pend_last_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fcnt_d = fcnt_q + 3'd1;
            2'b01:   fcnt_d = fcnt_q - 3'd1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    // Credit: words held after this edge, plus the read now on the bus, plus
    // the one about to be issued must all fit in the 4 slots.
    assign occ_d  = fcnt_d + {2'b00, out_valid_d};
    assign credit = (occ_d + {2'b00, rden_q}) < 3'd4;

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        rden_d      = 1'b0;
        rd_last_d   = 1'b0;
        pend_d      = rden_q;
        pend_last_d = rd_last_q;
        busy_d      = busy_q;
        cmd_ready_d = cmd_ready_q;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q && (bus.cmd_len != '0)) begin
                    // Skid buffer is empty in idle, so the first read needs no credit check.
                    rden_d      = 1'b1;
                    addr_d      = bus.cmd_addr;
                    next_addr_d = addr_inc(bus.cmd_addr);
                    rem_d       = bus.cmd_len - LenOne;
                    rd_last_d   = (bus.cmd_len == LenOne);
                    state_d     = StIssue;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                end
            end
            StIssue: begin
                if (rem_q == '0) begin
                    state_d = StDrain;
                end else if (credit) begin
                    rden_d      = 1'b1;
                    addr_d      = next_addr_q;
                    next_addr_d = addr_inc(next_addr_q);
                    rem_d       = rem_q - LenOne;
                    rd_last_d   = (rem_q == LenOne);
                    if (rem_q == LenOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && out_last_q) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            state_q     <= StIdle;
            next_addr_q <= '0;
            rem_q       <= '0;
            rden_q      <= 1'b0;
            addr_q      <= '0;
            rd_last_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            rem_q       <= rem_d;
            rden_q      <= rden_d;
            addr_q      <= addr_d;
            rd_last_q   <= rd_last_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.address_b = addr_q;
    assign bus.rden_b    = rden_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;

endmodule
